// File: rtl/l2_port_arbiter.sv
// Two-port arbiter sharing one L2 port between the I-fetch and D-cache miss paths.
// One transaction in flight; a watchdog aborts a WAIT that never completes.
module l2_port_arbiter #(
    parameter int ADDRBITS     = 32,
    parameter int WORDBITS     = 32,
    parameter bit PRIO_DATA    = 1'b0,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [2:0]          op0,
    input  logic [2:0]          op1,
    input  logic [ADDRBITS-1:0] addr0,
    input  logic [ADDRBITS-1:0] addr1,
    input  logic [WORDBITS-1:0] wdata0,
    input  logic [WORDBITS-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [WORDBITS-1:0] rdata0,
    output logic [WORDBITS-1:0] rdata1,
    output logic                nx_valid,
    output logic [2:0]          nx_op,
    output logic [ADDRBITS-1:0] nx_addr,
    output logic [WORDBITS-1:0] nx_wdata,
    input  logic                nx_ready,
    input  logic                nx_done,
    input  logic [WORDBITS-1:0] nx_rdata,
    output logic                busy,
    output logic                timeout_err
);

    localparam int WB = $clog2(TIMEOUT + 1);
    localparam int SB = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t        state;
    logic          owner;
    logic          rr_last;
    logic [SB-1:0] starve_cnt;
    logic [WB-1:0] wait_cnt;

    logic elig0;
    logic elig1;
    logic pick1;

    // NOP (0) and reserved codes (5..7) are never granted.
    always_comb begin
        elig0 = req0 && (op0 >= 3'd1) && (op0 <= 3'd4);
        elig1 = req1 && (op1 >= 3'd1) && (op1 <= 3'd4);
        pick1 = elig1;
        if (elig0 && elig1) begin
            if (PRIO_DATA)
                pick1 = (starve_cnt != SB'(STARVE_LIMIT));
            else
                pick1 = !rr_last;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            rr_last     <= 1'b1;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            nx_valid    <= 1'b0;
            nx_op       <= '0;
            nx_addr     <= '0;
            nx_wdata    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            unique case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        owner    <= pick1;
                        gnt0     <= !pick1;
                        gnt1     <= pick1;
                        nx_op    <= pick1 ? op1 : op0;
                        nx_addr  <= pick1 ? addr1 : addr0;
                        nx_wdata <= pick1 ? wdata1 : wdata0;
                        nx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                        if (elig0 && elig1)
                            rr_last <= pick1;
                        // Saturates; the forced port-0 grant clears it.
                        if (!pick1)
                            starve_cnt <= '0;
                        else if (elig0 && starve_cnt != SB'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (nx_ready) begin
                        nx_valid <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (nx_done) begin
                        done0  <= !owner;
                        done1  <= owner;
                        rdata0 <= owner ? '0 : nx_rdata;
                        rdata1 <= owner ? nx_rdata : '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (wait_cnt == WB'(TIMEOUT)) begin
                        done0       <= !owner;
                        done1       <= owner;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: a round-robin/timeout instance (a)
// and a data-priority instance (b) driven by the same stimulus.
module tb_l2_port_arbiter;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 0, req1 = 0;
    logic [2:0]  op0 = 0, op1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        nx_ready = 0, nx_done = 0;
    logic [31:0] nx_rdata = 0;

    logic        gnt0_a, gnt1_a, done0_a, done1_a, nx_valid_a, busy_a, terr_a;
    logic [31:0] rdata0_a, rdata1_a, nx_addr_a, nx_wdata_a;
    logic [2:0]  nx_op_a;
    logic        gnt0_b, gnt1_b, done0_b, done1_b, nx_valid_b, busy_b, terr_b;
    logic [31:0] rdata0_b, rdata1_b, nx_addr_b, nx_wdata_b;
    logic [2:0]  nx_op_b;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    l2_port_arbiter #(.PRIO_DATA(1'b0), .STARVE_LIMIT(4), .TIMEOUT(8)) u_a (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a),
        .nx_valid(nx_valid_a), .nx_op(nx_op_a), .nx_addr(nx_addr_a),
        .nx_wdata(nx_wdata_a), .nx_ready(nx_ready), .nx_done(nx_done),
        .nx_rdata(nx_rdata), .busy(busy_a), .timeout_err(terr_a)
    );

    l2_port_arbiter #(.PRIO_DATA(1'b1), .STARVE_LIMIT(4), .TIMEOUT(8)) u_b (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b),
        .nx_valid(nx_valid_b), .nx_op(nx_op_b), .nx_addr(nx_addr_b),
        .nx_wdata(nx_wdata_b), .nx_ready(nx_ready), .nx_done(nx_done),
        .nx_rdata(nx_rdata), .busy(busy_b), .timeout_err(terr_b)
    );

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req0 = 0; req1 = 0; op0 = NOP; op1 = NOP;
        nx_ready = 0; nx_done = 0; nx_rdata = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Waits for a grant on the chosen instance, then completes the transaction.
    task automatic serve(input bit use_b, output int port);
        port = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (use_b ? (gnt0_b || gnt1_b) : (gnt0_a || gnt1_a)) begin
                port = use_b ? int'(gnt1_b) : int'(gnt1_a);
                break;
            end
        end
        @(negedge clock);
        nx_rdata = 32'h0000_00AA;
        nx_done = 1'b1;
        @(negedge clock);
        nx_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy_a, nx_valid_a, gnt0_a, gnt1_a, done0_a, done1_a, terr_a} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {busy_a, nx_valid_a, gnt0_a, gnt1_a, done0_a, done1_a, terr_a});
        end
        total++;
        if ({rdata0_a, rdata1_a, nx_addr_a, nx_wdata_a} !== 128'b0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {rdata0_a, rdata1_a, nx_addr_a, nx_wdata_a});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1; op0 = READ; addr0 = 32'h0000_1040; nx_ready = 1;
        @(negedge clock);
        total++;
        if ({gnt0_a, gnt1_a, nx_valid_a, busy_a} !== 4'b1011) begin
            bad++;
            $display("FAIL read_grant got=%b want=1011", {gnt0_a, gnt1_a, nx_valid_a, busy_a});
        end
        total++;
        if (nx_op_a !== READ || nx_addr_a !== 32'h0000_1040) begin
            bad++;
            $display("FAIL read_cmd got=%0d/%h want=1/00001040", nx_op_a, nx_addr_a);
        end
        req0 = 0;
        @(negedge clock);
        total++;
        if (nx_valid_a !== 1'b0 || gnt0_a !== 1'b0) begin
            bad++;
            $display("FAIL read_accept got=%b%b want=00", nx_valid_a, gnt0_a);
        end
        repeat (2) @(negedge clock);
        nx_done = 1; nx_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        nx_done = 0; nx_rdata = 0;
        total++;
        if (done0_a !== 1'b1 || rdata0_a !== 32'hDEAD_BEEF || done1_a !== 1'b0) begin
            bad++;
            $display("FAIL read_done got=%b/%h/%b want=1/deadbeef/0", done0_a, rdata0_a, done1_a);
        end
        @(negedge clock);
        total++;
        if (done0_a !== 1'b0 || rdata0_a !== 32'h0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL read_after got=%b/%h/%b want=0/0/0", done0_a, rdata0_a, busy_a);
        end
    endtask

    task automatic test_round_robin();
        int p;
        int exp [4] = '{0, 1, 0, 1};
        do_reset();
        req0 = 1; req1 = 1; op0 = READ; op1 = READ; nx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, p);
            total++;
            if (p !== exp[i]) begin
                bad++;
                $display("FAIL rr_order[%0d] got=%0d want=%0d", i, p, exp[i]);
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_priority();
        int p;
        int exp [6] = '{1, 1, 1, 1, 0, 1};
        do_reset();
        req0 = 1; req1 = 1; op0 = READ; op1 = READ; nx_ready = 1;
        for (int i = 0; i < 6; i++) begin
            serve(1'b1, p);
            total++;
            if (p !== exp[i]) begin
                bad++;
                $display("FAIL prio_order[%0d] got=%0d want=%0d", i, p, exp[i]);
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_ready_stall();
        int p;
        do_reset();
        req0 = 1; op0 = WRITE; addr0 = 32'h0000_2000; wdata0 = 32'h1234_5678; nx_ready = 0;
        @(negedge clock);
        req0 = 0;
        total++;
        if (gnt0_a !== 1'b1) begin
            bad++;
            $display("FAIL stall_grant got=%b want=1", gnt0_a);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (nx_valid_a !== 1'b1 || nx_wdata_a !== 32'h1234_5678 || nx_op_a !== WRITE) begin
                bad++;
                $display("FAIL stall_hold[%0d] got=%b/%h/%0d want=1/12345678/2",
                         i, nx_valid_a, nx_wdata_a, nx_op_a);
            end
            @(negedge clock);
        end
        nx_ready = 1;
        @(negedge clock);
        total++;
        if (nx_valid_a !== 1'b0 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL stall_accept got=%b%b want=01", nx_valid_a, busy_a);
        end
        nx_done = 1; nx_rdata = 32'h0;
        @(negedge clock);
        nx_done = 0;
        total++;
        if (done0_a !== 1'b1) begin
            bad++;
            $display("FAIL stall_done got=%b want=1", done0_a);
        end
        p = 0;
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req0 = 1; op0 = READ; addr0 = 32'h0000_3000; nx_ready = 1;
        @(negedge clock);
        req0 = 0;
        @(negedge clock);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            cnt++;
            if (done0_a) break;
        end
        total++;
        if (done0_a !== 1'b1 || cnt < 8 || cnt > 9) begin
            bad++;
            $display("FAIL timeout_cycles got=%0d/%b want=8..9/1", cnt, done0_a);
        end
        total++;
        if (rdata0_a !== 32'h0 || terr_a !== 1'b1) begin
            bad++;
            $display("FAIL timeout_flag got=%h/%b want=0/1", rdata0_a, terr_a);
        end
        req0 = 1; op0 = READ;
        @(negedge clock);
        req0 = 0;
        @(negedge clock);
        nx_done = 1; nx_rdata = 32'h5555_AAAA;
        @(negedge clock);
        nx_done = 0;
        total++;
        if (done0_a !== 1'b1 || rdata0_a !== 32'h5555_AAAA || terr_a !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=%b/%h/%b want=1/5555aaaa/1", done0_a, rdata0_a, terr_a);
        end
    endtask

    task automatic test_reset_mid_wait();
        req0 = 1; op0 = READ; nx_ready = 1;
        @(negedge clock);
        req0 = 0;
        @(negedge clock);
        total++;
        if (busy_a !== 1'b1 || terr_a !== 1'b1) begin
            bad++;
            $display("FAIL midwait_pre got=%b%b want=11", busy_a, terr_a);
        end
        @(negedge clock);
        reset_n = 0;
        #1;
        total++;
        if (busy_a !== 1'b0 || nx_valid_a !== 1'b0 || terr_a !== 1'b0) begin
            bad++;
            $display("FAIL midwait_reset got=%b%b%b want=000", busy_a, nx_valid_a, terr_a);
        end
        nx_done = 1; nx_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            nx_done = 0;
            total++;
            if (done0_a !== 1'b0 || done1_a !== 1'b0) begin
                bad++;
                $display("FAIL midwait_nodone[%0d] got=%b%b want=00", i, done0_a, done1_a);
            end
        end
        reset_n = 1;
        req0 = 1; op0 = NOP; req1 = 1; op1 = 3'd6;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            total++;
            if (gnt0_a !== 1'b0 || gnt1_a !== 1'b0 || busy_a !== 1'b0) begin
                bad++;
                $display("FAIL nop_grant[%0d] got=%b%b%b want=000", i, gnt0_a, gnt1_a, busy_a);
            end
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_priority();
        test_ready_stall();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
